// File: rtl/store_commit_queue.sv
// Multi-channel committed-store FIFO feeding the memory write port, with load hazard checks.
// Define STB_FORWARD_EN to enable store-to-load forwarding from the youngest overlapping entry.
package stcq_pkg;
    typedef enum logic [2:0] {
        BYTE   = 3'd0,
        HALF   = 3'd1,
        WORD   = 3'd2,
        BYTE_U = 3'd4,
        HALF_U = 3'd5
    } ldst_mode;
endpackage

module store_commit_queue
    import stcq_pkg::*;
#(
    parameter int CH    = 2,
    parameter int DEPTH = 8,
    parameter int LP    = 2,
    localparam int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CH-1:0]           in_valid,
    input  logic [CH-1:0][31:0]     in_addr,
    input  logic [CH-1:0][31:0]     in_data,
    input  ldst_mode [CH-1:0]       in_mode,
    output logic                    in_ready,
    input  logic                    mem_stall,
    output logic                    we,
    output logic [31:0]             wa,
    output logic [31:0]             wd,
    output ldst_mode                wm,
    input  logic [LP-1:0][31:0]     ld_addr,
    input  ldst_mode [LP-1:0]       ld_mode,
    output logic [LP-1:0]           ld_conflict,
    output logic [LP-1:0]           ld_hit,
    output logic [LP-1:0][31:0]     ld_data,
    output logic [DEPTH_LOG:0]      count,
    output logic                    empty
);

    logic [31:0]          addr_q [DEPTH];
    logic [31:0]          data_q [DEPTH];
    ldst_mode             mode_q [DEPTH];
    logic [DEPTH-1:0]     vld_q;
    logic [DEPTH_LOG-1:0] head_q, head_d, tail_q, tail_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic                 push, pop;
    logic [DEPTH_LOG:0]   npush;
    logic [DEPTH_LOG-1:0] slot [CH];
    logic [DEPTH_LOG-1:0] scan [DEPTH];

    function automatic logic [2:0] msize(input ldst_mode m);
        case (m)
            BYTE, BYTE_U: msize = 3'd1;
            HALF, HALF_U: msize = 3'd2;
            default:      msize = 3'd4;
        endcase
    endfunction

    // 33-bit ends so ranges touching the top of the address space do not wrap
    function automatic logic ovl(input logic [31:0] sa, input ldst_mode sm,
                                 input logic [31:0] la, input ldst_mode lm);
        logic [32:0] se, le;
        se  = {1'b0, sa} + 33'(msize(sm));
        le  = {1'b0, la} + 33'(msize(lm));
        ovl = ({1'b0, sa} < le) && ({1'b0, la} < se);
    endfunction

    always_comb begin
        in_ready = ((DEPTH_LOG+1)'(DEPTH) - count_q) >= (DEPTH_LOG+1)'(CH);
        push     = in_ready;
        pop      = (count_q != '0) && !mem_stall;
        npush    = '0;
        for (int i = 0; i < CH; i++) begin
            slot[i] = tail_q + DEPTH_LOG'(npush);
            if (in_valid[i]) npush = npush + (DEPTH_LOG+1)'(1);
        end
        head_d  = head_q + DEPTH_LOG'(pop);
        tail_d  = push ? tail_q + DEPTH_LOG'(npush) : tail_q;
        count_d = count_q + (push ? npush : '0) - (DEPTH_LOG+1)'(pop);
        for (int k = 0; k < DEPTH; k++) scan[k] = head_q + DEPTH_LOG'(k);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (pop) vld_q[head_q] <= 1'b0;
            if (push)
                for (int i = 0; i < CH; i++)
                    if (in_valid[i]) vld_q[slot[i]] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            for (int i = 0; i < CH; i++)
                if (in_valid[i]) begin
                    addr_q[slot[i]] <= in_addr[i];
                    data_q[slot[i]] <= in_data[i];
                    mode_q[slot[i]] <= in_mode[i];
                end
    end

    always_comb begin
        empty = (count_q == '0);
        count = count_q;
        we    = !empty;
        wa    = empty ? 32'h0 : addr_q[head_q];
        wd    = empty ? 32'h0 : data_q[head_q];
        wm    = empty ? WORD : mode_q[head_q];
    end

`ifdef STB_FORWARD_EN
    logic [LP-1:0]        found;
    logic [DEPTH_LOG-1:0] yidx [LP];

    function automatic logic [31:0] fext(input logic [31:0] d, input ldst_mode m);
        case (m)
            BYTE:    fext = {{24{d[7]}}, d[7:0]};
            BYTE_U:  fext = {24'h0, d[7:0]};
            HALF:    fext = {{16{d[15]}}, d[15:0]};
            HALF_U:  fext = {16'h0, d[15:0]};
            default: fext = d;
        endcase
    endfunction

    // Scan oldest to youngest so the last match is the youngest store
    always_comb begin
        for (int p = 0; p < LP; p++) begin
            found[p]       = 1'b0;
            yidx[p]        = '0;
            ld_conflict[p] = 1'b0;
            ld_hit[p]      = 1'b0;
            ld_data[p]     = 32'h0;
            for (int k = 0; k < DEPTH; k++)
                if (vld_q[scan[k]] &&
                    ovl(addr_q[scan[k]], mode_q[scan[k]], ld_addr[p], ld_mode[p])) begin
                    found[p] = 1'b1;
                    yidx[p]  = scan[k];
                end
            if (found[p]) begin
                if (addr_q[yidx[p]] == ld_addr[p] &&
                    msize(ld_mode[p]) <= msize(mode_q[yidx[p]])) begin
                    ld_hit[p]  = 1'b1;
                    ld_data[p] = fext(data_q[yidx[p]], ld_mode[p]);
                end else begin
                    ld_conflict[p] = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        ld_hit  = '0;
        ld_data = '0;
        for (int p = 0; p < LP; p++) begin
            ld_conflict[p] = 1'b0;
            for (int k = 0; k < DEPTH; k++)
                if (vld_q[scan[k]] &&
                    ovl(addr_q[scan[k]], mode_q[scan[k]], ld_addr[p], ld_mode[p]))
                    ld_conflict[p] = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_store_commit_queue.sv
// Random and directed bench for store_commit_queue against a queue-based reference model.
// Forwarding expectations follow STB_FORWARD_EN when the bench is built with it.
module tb_store_commit_queue;
    import stcq_pkg::*;

    localparam int CH    = 2;
    localparam int DEPTH = 8;
    localparam int LP    = 2;
    localparam int DL    = $clog2(DEPTH);

    logic                clk = 1'b0;
    logic                reset;
    logic [CH-1:0]       in_valid;
    logic [CH-1:0][31:0] in_addr, in_data;
    ldst_mode [CH-1:0]   in_mode;
    logic                in_ready;
    logic                mem_stall;
    logic                we;
    logic [31:0]         wa, wd;
    ldst_mode            wm;
    logic [LP-1:0][31:0] ld_addr;
    ldst_mode [LP-1:0]   ld_mode;
    logic [LP-1:0]       ld_conflict, ld_hit;
    logic [LP-1:0][31:0] ld_data;
    logic [DL:0]         count;
    logic                empty;

    store_commit_queue #(.CH(CH), .DEPTH(DEPTH), .LP(LP)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
        .in_mode(in_mode), .in_ready(in_ready), .mem_stall(mem_stall),
        .we(we), .wa(wa), .wd(wd), .wm(wm),
        .ld_addr(ld_addr), .ld_mode(ld_mode),
        .ld_conflict(ld_conflict), .ld_hit(ld_hit), .ld_data(ld_data),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        ldst_mode    m;
    } ent_t;

    ent_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sz(input ldst_mode m);
        if (m == BYTE || m == BYTE_U) return 1;
        if (m == HALF || m == HALF_U) return 2;
        return 4;
    endfunction

    function automatic ldst_mode rmode();
        case ($urandom_range(0, 4))
            0: return BYTE;
            1: return HALF;
            2: return WORD;
            3: return BYTE_U;
            default: return HALF_U;
        endcase
    endfunction

    task automatic check_all();
        logic [31:0] mask, v;
        int y, ls;
        longint la;
        chk("count", 64'(count), 64'(q.size()));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("in_ready", 64'(in_ready), 64'((DEPTH - q.size()) >= CH));
        chk("we", 64'(we), 64'(q.size() != 0));
        chk("wa", 64'(wa), q.size() != 0 ? 64'(q[0].a) : 64'h0);
        chk("wd", 64'(wd), q.size() != 0 ? 64'(q[0].d) : 64'h0);
        chk("wm", 64'(wm), q.size() != 0 ? 64'(q[0].m) : 64'(WORD));
        for (int p = 0; p < LP; p++) begin
            y  = -1;
            ls = sz(ld_mode[p]);
            la = longint'(ld_addr[p]);
            for (int i = 0; i < q.size(); i++)
                if (longint'(q[i].a) < la + ls && la < longint'(q[i].a) + sz(q[i].m))
                    y = i;
`ifdef STB_FORWARD_EN
            if (y >= 0 && q[y].a == ld_addr[p] && ls <= sz(q[y].m)) begin
                mask = (ls == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * ls)) - 1);
                v = q[y].d & mask;
                if ((ld_mode[p] == BYTE || ld_mode[p] == HALF) && v[8*ls-1])
                    v = v | ~mask;
                chk($sformatf("ld_hit%0d", p), 64'(ld_hit[p]), 64'd1);
                chk($sformatf("ld_conflict%0d", p), 64'(ld_conflict[p]), 64'd0);
                chk($sformatf("ld_data%0d", p), 64'(ld_data[p]), 64'(v));
            end else begin
                chk($sformatf("ld_hit%0d", p), 64'(ld_hit[p]), 64'd0);
                chk($sformatf("ld_conflict%0d", p), 64'(ld_conflict[p]), 64'(y >= 0));
                chk($sformatf("ld_data%0d", p), 64'(ld_data[p]), 64'd0);
            end
`else
            chk($sformatf("ld_hit%0d", p), 64'(ld_hit[p]), 64'd0);
            chk($sformatf("ld_conflict%0d", p), 64'(ld_conflict[p]), 64'(y >= 0));
            chk($sformatf("ld_data%0d", p), 64'(ld_data[p]), 64'd0);
`endif
        end
    endtask

    task automatic model_update();
        int   n0;
        ent_t e;
        if (reset) begin
            q.delete();
            return;
        end
        n0 = q.size();
        if (n0 != 0 && !mem_stall) e = q.pop_front();
        if (DEPTH - n0 >= CH)
            for (int i = 0; i < CH; i++)
                if (in_valid[i]) begin
                    e.a = in_addr[i];
                    e.d = in_data[i];
                    e.m = in_mode[i];
                    q.push_back(e);
                end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset     = 1'b0;
        in_valid  = '0;
        in_addr   = '0;
        in_data   = '0;
        in_mode   = {CH{WORD}};
        mem_stall = 1'b0;
        ld_addr   = {LP{32'hFFFF_0000}};
        ld_mode   = {LP{WORD}};
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_cycle();
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_rdy", 64'(in_ready), 64'd1);
        reset = 1'b0;
        run_cycle();

        in_valid   = 2'b11;
        in_addr[0] = 32'h100;
        in_addr[1] = 32'h104;
        in_data[0] = 32'hAAAA_AAAA;
        in_data[1] = 32'hBBBB_BBBB;
        run_cycle();
        in_valid = '0;
        chk("two_we", 64'(we), 64'd1);
        chk("two_wa0", 64'(wa), 64'h100);
        run_cycle();
        chk("two_wa1", 64'(wa), 64'h104);
        chk("two_wd1", 64'(wd), 64'hBBBB_BBBB);
        run_cycle();
        chk("two_empty", 64'(empty), 64'd1);

        in_valid   = 2'b01;
        in_addr[0] = 32'h200;
        in_addr[1] = 32'h2FC;
        run_cycle();
        in_valid = '0;
        chk("gap_count", 64'(count), 64'd1);
        chk("gap_wa", 64'(wa), 64'h200);
        run_cycle();
        chk("gap_empty", 64'(empty), 64'd1);

        mem_stall = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_valid   = 2'b11;
            in_addr[0] = 32'h500 + 32'(8 * j);
            in_addr[1] = 32'h504 + 32'(8 * j);
            in_data[0] = 32'(j * 2);
            in_data[1] = 32'(j * 2 + 1);
            run_cycle();
        end
        in_valid = '0;
        chk("full_count", 64'(count), 64'd8);
        chk("full_rdy", 64'(in_ready), 64'd0);
        mem_stall = 1'b0;
        run_cycle();
        chk("pop1_count", 64'(count), 64'd7);
        chk("pop1_rdy", 64'(in_ready), 64'd0);
        for (int j = 0; j < 7; j++) run_cycle();
        chk("wrap_empty", 64'(empty), 64'd1);

        mem_stall  = 1'b1;
        in_valid   = 2'b01;
        in_addr[0] = 32'h300;
        in_data[0] = 32'hCAFE_F00D;
        in_mode[0] = WORD;
        run_cycle();
        in_valid   = '0;
        ld_addr[0] = 32'h302;
        ld_mode[0] = HALF;
        #1;
        chk("haz_conf", 64'(ld_conflict[0]), 64'd1);
        chk("haz_hit", 64'(ld_hit[0]), 64'd0);
        in_valid   = 2'b01;
        in_addr[0] = 32'h400;
        in_data[0] = 32'h1234_5680;
        in_mode[0] = BYTE;
        run_cycle();
        in_valid   = '0;
        ld_addr[1] = 32'h400;
        ld_mode[1] = BYTE;
        #1;
`ifdef STB_FORWARD_EN
        chk("fwd_hit", 64'(ld_hit[1]), 64'd1);
        chk("fwd_sdata", 64'(ld_data[1]), 64'hFFFF_FF80);
        ld_mode[1] = BYTE_U;
        #1;
        chk("fwd_udata", 64'(ld_data[1]), 64'h0000_0080);
`else
        chk("nofwd_conf", 64'(ld_conflict[1]), 64'd1);
        chk("nofwd_hit", 64'(ld_hit[1]), 64'd0);
`endif
        run_cycle();
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        chk("midrst_empty", 64'(empty), 64'd1);
        run_cycle();

        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            mem_stall = ($urandom_range(0, 2) == 0);
            in_valid  = CH'($urandom);
            for (int i = 0; i < CH; i++) begin
                in_addr[i] = 32'h300 + 32'($urandom_range(0, 15));
                in_data[i] = $urandom;
                in_mode[i] = rmode();
            end
            for (int p = 0; p < LP; p++) begin
                ld_addr[p] = 32'h300 + 32'($urandom_range(0, 19));
                ld_mode[p] = rmode();
            end
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
